// File: rtl/cache_arbiter.sv
// cache_arbiter: two-port round-robin arbiter in front of a single-ported cache.
// A granted request is registered onto c_data/c_address/c_mode, the arbiter waits
// for the cache to drop c_response (or for a timeout), then pulses the granted
// port's ack for one cycle with read data on rdata.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   req0/1, mode0/1           request (held until ack), 1 = write / 0 = read
//   addr0/1, wdata0/1         word address and write data per port
//   ack0/1, rdata0/1          one-cycle completion pulse, read data valid with ack
//   c_data, c_address, c_mode request presented to the cache (change on grant only)
//   c_response, c_out         cache busy flag and cache read data
//   busy                      high while a transaction is in WAIT or DONE
//   miss_count                saturating count of transactions that saw a miss
//   err                       sticky timeout flag, cleared only by reset
module cache_arbiter #(
  parameter int unsigned SIZE_RAM = 4096,
  parameter int unsigned TIMEOUT  = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0,
  input  logic        req1,
  input  logic        mode0,
  input  logic        mode1,
  input  logic [31:0] addr0,
  input  logic [31:0] addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        ack0,
  output logic        ack1,
  output logic [31:0] rdata0,
  output logic [31:0] rdata1,
  output logic [31:0] c_data,
  output logic [31:0] c_address,
  output logic        c_mode,
  input  logic        c_response,
  input  logic [31:0] c_out,
  output logic        busy,
  output logic [15:0] miss_count,
  output logic        err
);

  localparam int unsigned CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic             grant;        // port owning the current transaction
  logic             last_grant;   // port granted most recently
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_next_c;

  // Sole requester wins; on contention the port not granted last wins.
  assign grant_next_c = (req0 && req1) ? ~last_grant : req1;

  // The cache compares addresses modulo its RAM size, so present the reduced index.
  function automatic logic [31:0] ram_index(input logic [31:0] a);
    return a % 32'(SIZE_RAM);
  endfunction

  // Arbiter FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      grant      <= 1'b0;
      last_grant <= 1'b1;
      wait_cnt   <= '0;
      ack0       <= 1'b0;
      ack1       <= 1'b0;
      rdata0     <= '0;
      rdata1     <= '0;
      c_data     <= '0;
      c_address  <= '0;
      c_mode     <= 1'b0;
      busy       <= 1'b0;
      miss_count <= '0;
      err        <= 1'b0;
    end else begin
      ack0 <= 1'b0;
      ack1 <= 1'b0;
      case (state)
        IDLE: begin
          if (req0 || req1) begin
            grant      <= grant_next_c;
            last_grant <= grant_next_c;
            c_data     <= grant_next_c ? wdata1 : wdata0;
            c_address  <= ram_index(grant_next_c ? addr1 : addr0);
            c_mode     <= grant_next_c ? mode1 : mode0;
            wait_cnt   <= '0;
            busy       <= 1'b1;
            state      <= WAIT;
          end
        end
        WAIT: begin
          if (!c_response) begin
            // Writes leave the requester's read data untouched.
            if (!c_mode) begin
              if (grant) rdata1 <= c_out;
              else       rdata0 <= c_out;
            end
            state <= DONE;
          end else begin
            // A miss is counted once per transaction, on the first busy sample.
            if (wait_cnt == '0 && miss_count != 16'hFFFF)
              miss_count <= miss_count + 16'd1;
            wait_cnt <= wait_cnt + CNT_W'(1);
            if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
              err   <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          if (grant) ack1 <= 1'b1;
          else       ack0 <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter; the cache is driven by hand each step.
module tb_cache_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, mode0, mode1;
  logic [31:0] addr0, addr1, wdata0, wdata1;
  logic        ack0, ack1;
  logic [31:0] rdata0, rdata1, c_data, c_address;
  logic        c_mode, c_response, busy, err;
  logic [31:0] c_out;
  logic [15:0] miss_count;

  int n_checks = 0;
  int n_fail   = 0;

  cache_arbiter #(.SIZE_RAM(4096), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .mode0(mode0), .mode1(mode1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata0(rdata0), .rdata1(rdata1),
    .c_data(c_data), .c_address(c_address), .c_mode(c_mode),
    .c_response(c_response), .c_out(c_out),
    .busy(busy), .miss_count(miss_count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are read 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Both acks must never be seen high together.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      n_checks++;
      assert (!(ack0 === 1'b1 && ack1 === 1'b1)) else begin
        n_fail++;
        $error("FAIL ack_exclusive: observed ack0=%b ack1=%b expected not both", ack0, ack1);
      end
    end
  end

  initial begin
    logic [31:0] exp_addr;
    logic        exp_port;

    rst = 1'b1; req0 = 0; req1 = 0; mode0 = 0; mode1 = 0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    c_response = 1'b0; c_out = '0;

    // Reset state
    tick(); tick();
    chk("rst_ack0", 32'(ack0), 32'd0);
    chk("rst_ack1", 32'(ack1), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_caddr", c_address, 32'd0);
    chk("rst_miss", 32'(miss_count), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst = 1'b0;
    tick();
    chk("idle_busy", 32'(busy), 32'd0);

    // Port 0 read hit: ack0 after edge t+2
    addr0 = 32'h10; mode0 = 1'b0; req0 = 1'b1; c_out = 32'hDEADBEEF;
    tick();                                   // t
    chk("hit_grant_busy", 32'(busy), 32'd1);
    chk("hit_caddr", c_address, 32'h10);
    chk("hit_cmode", 32'(c_mode), 32'd0);
    tick();                                   // t+1
    chk("hit_ack0_early", 32'(ack0), 32'd0);
    tick();                                   // t+2
    chk("hit_ack0", 32'(ack0), 32'd1);
    chk("hit_rdata0", rdata0, 32'hDEADBEEF);
    chk("hit_miss", 32'(miss_count), 32'd0);
    req0 = 1'b0;
    tick();
    chk("hit_ack0_pulse", 32'(ack0), 32'd0);

    // Port 1 read miss: 3 busy samples then ready, ack1 after edge t+5
    addr1 = 32'h40; mode1 = 1'b0; req1 = 1'b1; c_response = 1'b1; c_out = 32'h1234;
    tick();                                   // t
    chk("miss_caddr", c_address, 32'h40);
    tick();                                   // t+1
    chk("miss_count_1", 32'(miss_count), 32'd1);
    tick(); tick();                           // t+2, t+3
    c_response = 1'b0;
    tick();                                   // t+4
    chk("miss_ack1_early", 32'(ack1), 32'd0);
    tick();                                   // t+5
    chk("miss_ack1", 32'(ack1), 32'd1);
    chk("miss_rdata1", rdata1, 32'h1234);
    chk("miss_count_hold", 32'(miss_count), 32'd1);
    req1 = 1'b0;
    tick();

    // Contention: both held for 4 transactions, grants 0,1,0,1
    req0 = 1'b1; req1 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr0 = 32'h100 + 32'(i); addr1 = 32'h200 + 32'(i);
      c_out = 32'hC000_0000 + 32'(i);
      exp_port = 1'(i % 2);
      exp_addr = exp_port ? addr1 : addr0;
      tick();                                 // grant edge
      chk("rr_caddr_grant", c_address, exp_addr);
      addr0 = 32'h0000_0FF0; addr1 = 32'h0000_0FF4;
      tick();
      chk("rr_caddr_hold1", c_address, exp_addr);
      tick();
      chk("rr_caddr_hold2", c_address, exp_addr);
      chk("rr_ack0", 32'(ack0), 32'(!exp_port));
      chk("rr_ack1", 32'(ack1), 32'(exp_port));
      chk("rr_rdata", exp_port ? rdata1 : rdata0, 32'hC000_0000 + 32'(i));
    end
    req0 = 1'b0; req1 = 1'b0;
    tick();

    // Port 0 write: rdata0 keeps the value from contention transaction 2
    addr0 = 32'h20; wdata0 = 32'h55; mode0 = 1'b1; req0 = 1'b1; c_out = 32'hBAD0_BAD0;
    tick();
    chk("wr_cmode", 32'(c_mode), 32'd1);
    chk("wr_cdata", c_data, 32'h55);
    chk("wr_caddr", c_address, 32'h20);
    tick(); tick();
    chk("wr_ack0", 32'(ack0), 32'd1);
    chk("wr_rdata0", rdata0, 32'hC000_0002);
    req0 = 1'b0; mode0 = 1'b0;
    tick();

    // Timeout: c_response stuck high with TIMEOUT = 4
    addr1 = 32'h80; req1 = 1'b1; c_response = 1'b1; c_out = 32'h7777;
    tick();                                   // t
    tick(); tick(); tick();                   // t+1..t+3
    chk("to_err_early", 32'(err), 32'd0);
    tick();                                   // t+4
    chk("to_err", 32'(err), 32'd1);
    tick();                                   // t+5
    chk("to_ack1", 32'(ack1), 32'd1);
    chk("to_rdata1", rdata1, 32'hC000_0003);
    chk("to_miss", 32'(miss_count), 32'd2);
    req1 = 1'b0;
    tick();
    chk("to_ack1_once", 32'(ack1), 32'd0);
    tick(); tick();
    chk("to_ack1_none", 32'(ack1), 32'd0);
    chk("to_err_sticky", 32'(err), 32'd1);

    // Reset mid-WAIT on a port 0 transaction
    addr0 = 32'h300; req0 = 1'b1; c_response = 1'b1;
    tick();                                   // grant port 0
    tick();                                   // WAIT, miss counted
    chk("mr_miss", 32'(miss_count), 32'd3);
    #2 rst = 1'b1;
    #1;
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_err", 32'(err), 32'd0);
    chk("mr_miss0", 32'(miss_count), 32'd0);
    chk("mr_caddr", c_address, 32'd0);
    chk("mr_rdata1", rdata1, 32'd0);
    req0 = 1'b0; c_response = 1'b0;
    tick();
    rst = 1'b0;
    tick(); tick();
    chk("mr_no_ack0", 32'(ack0), 32'd0);
    addr0 = 32'h300; addr1 = 32'h400; req0 = 1'b1; req1 = 1'b1; c_out = 32'h5A5A;
    tick();
    chk("mr_grant_p0", c_address, 32'h300);
    tick(); tick();
    chk("mr_ack0", 32'(ack0), 32'd1);
    chk("mr_rdata0", rdata0, 32'h5A5A);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cache_arbiter.md
CACHE_ARBITER -- requirements
Module: cache_arbiter

Interface
REQ-001 Parameter SIZE_RAM, default 4096, backing-RAM word count; cache address compare is modulo this value.
REQ-002 Parameter TIMEOUT, default 255, maximum WAIT cycles before a transaction is forced complete.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-high.
REQ-005 req0 / req1  input  1  request from port 0 / port 1; held high until ack.
REQ-006 mode0 / mode1  input  1  1 = write, 0 = read.
REQ-007 addr0 / addr1  input  32  word address.
REQ-008 wdata0 / wdata1  input  32  write data; ignored for reads.
REQ-009 ack0 / ack1  output  1  one-cycle completion pulse.
REQ-010 rdata0 / rdata1  output  32  read data; valid while ack high.
REQ-011 c_data  output  32  data to cache.
REQ-012 c_address  output  32  address to cache.
REQ-013 c_mode  output  1  mode to cache.
REQ-014 c_response  input  1  cache busy (1 = miss fill in progress).
REQ-015 c_out  input  32  cache read data.
REQ-016 busy  output  1  high in WAIT and DONE.
REQ-017 miss_count  output  16  saturating count of transactions that saw c_response = 1.
REQ-018 err  output  1  sticky timeout flag.

Function
REQ-019 The block SHALL implement states IDLE, WAIT, DONE.
REQ-020 IDLE: if any req high, grant one port, register {wdata, addr, mode} of that port onto c_data/c_address/c_mode, clear wait counter, go to WAIT; else stay.
REQ-021 Arbitration SHALL be round-robin: single req wins; both high -> port not granted last; last-grant pointer resets to port 1 so port 0 wins first contention.
REQ-022 c_data/c_address/c_mode SHALL change only on a grant edge and hold otherwise, since the cache starts an operation on any change of these inputs.
REQ-023 WAIT: sample c_response each edge; 0 -> capture c_out into granted port's rdata, go to DONE.
REQ-024 WAIT: if c_response is 1 at the first WAIT sample, increment miss_count, saturating at 16'hFFFF.
REQ-025 WAIT: wait counter increments each edge with c_response = 1; at TIMEOUT, set err, go to DONE, rdata unchanged.
REQ-026 DONE: assert granted port's ack for exactly one cycle, then IDLE unconditionally.
REQ-027 Hit latency: req sampled at edge t -> ack high between edges t+2 and t+3; miss adds one cycle per busy sample.
REQ-028 Write transactions SHALL leave rdata unchanged and still pulse ack.
REQ-029 A request identical to the previous one (addr mod SIZE_RAM, data, mode) SHALL complete as a hit: the cache leaves c_response 0 and c_out unchanged.
REQ-030 Requester SHALL drop req by the edge ending ack; a req still high in IDLE is a new request.
REQ-031 Non-granted port's req SHALL be ignored until IDLE; no request is lost.
REQ-032 ack0 and ack1 SHALL never be high together.

Reset
REQ-033 rst high SHALL immediately force IDLE and zero ack0/1, rdata0/1, c_data, c_address, c_mode, busy, miss_count, err, wait counter; last-grant pointer = port 1.
REQ-034 Reset during WAIT SHALL abandon the transaction without ack; the cache may finish its fill independently.
REQ-035 First edge after rst falls SHALL behave as IDLE.

Verification
REQ-036 Port 0 read addr 0x10, c_response stays 0, c_out = 0xDEADBEEF -> ack0 at t+2, rdata0 = 0xDEADBEEF, miss_count = 0.
REQ-037 Port 1 read, c_response high for 3 samples then 0, c_out = 0x1234 -> ack1 at t+5, rdata1 = 0x1234, miss_count = 1.
REQ-038 req0 and req1 both held high for 4 transactions -> grants 0,1,0,1; c_* change only on grant edges.
REQ-039 Port 0 write addr 0x20 data 0x55 -> c_mode = 1, c_data = 0x55, ack0 pulses, rdata0 unchanged.
REQ-040 c_response stuck at 1, TIMEOUT = 4 -> err = 1, ack pulses once, err holds until rst.
REQ-041 rst asserted mid-WAIT -> all outputs zero same cycle, no ack; next request granted to port 0.
